// File: rtl/trace_frame_assembler_if.sv
// Frame-assembler bus: the trace word input stream, the frame handshake toward
// the demultiplexer, and the status counters.
interface trace_frame_assembler_if #(
    parameter int DEPTH = 4,
    parameter int CNTW  = 16
);
    logic                    WdAvail;
    logic [15:0]             PacketWd;
    logic                    PacketReset;
    logic                    FrameValid;
    logic [127:0]            FrameData;
    logic                    FrameReady;
    logic [$clog2(DEPTH):0]  fill;
    logic [CNTW-1:0]         dropCount;
    logic [CNTW-1:0]         abortCount;

    modport master (
        output WdAvail, PacketWd, PacketReset, FrameReady,
        input  FrameValid, FrameData, fill, dropCount, abortCount
    );

    modport slave (
        input  WdAvail, PacketWd, PacketReset, FrameReady,
        output FrameValid, FrameData, fill, dropCount, abortCount
    );
endinterface

// File: rtl/trace_frame_assembler.sv
// Packs 16-bit trace words into 128-bit TPIU frames and queues completed frames
// in a small circular buffer behind a valid/ready handshake.
module trace_frame_assembler #(
    parameter int DEPTH = 4,
    parameter int CNTW  = 16
) (
    input  logic                     traceClkin,
    input  logic                     rst,
    trace_frame_assembler_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0]   FULL_FILL = PW'(DEPTH);
    localparam logic [PW-1:0]   PTR_ONE   = PW'(1);
    localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_MAX   = {CNTW{1'b1}};

    logic [111:0]    asm_q, asm_d;
    logic [2:0]      idx_q, idx_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] drop_q, drop_d;
    logic [CNTW-1:0] abort_q, abort_d;
    logic [127:0]    buf_q [DEPTH];

    logic [PW-1:0]   fill_s;
    logic            pop_s;
    logic            frame_done_s;
    logic            push_s;

    // Next-state for assembly, pointers and counters.
    always_comb begin
        asm_d        = asm_q;
        idx_d        = idx_q;
        abort_d      = abort_q;
        drop_d       = drop_q;
        frame_done_s = 1'b0;
        fill_s       = wr_ptr_q - rd_ptr_q;
        pop_s        = (fill_s != {PW{1'b0}}) && bus.FrameReady;

        if (bus.PacketReset) begin
            idx_d = 3'd0;
            if ((idx_q != 3'd0) && (abort_q != CNT_MAX)) begin
                abort_d = abort_q + CNT_ONE;
            end else begin
                abort_d = abort_q;
            end
        end else if (bus.WdAvail) begin
            if (idx_q != 3'd7) begin
                asm_d[{idx_q, 4'b0000} +: 16] = bus.PacketWd;
                idx_d                         = idx_q + 3'd1;
            end else begin
                frame_done_s = 1'b1;
                idx_d        = 3'd0;
            end
        end else begin
            idx_d = idx_q;
        end

        // A pop this cycle frees a slot, so a full buffer can still accept.
        push_s = frame_done_s && ((fill_s < FULL_FILL) || pop_s);
        if (frame_done_s && !push_s && (drop_q != CNT_MAX)) begin
            drop_d = drop_q + CNT_ONE;
        end else begin
            drop_d = drop_q;
        end

        wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge traceClkin) begin
        if (rst) begin
            asm_q    <= 112'd0;
            idx_q    <= 3'd0;
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            drop_q   <= {CNTW{1'b0}};
            abort_q  <= {CNTW{1'b0}};
        end else begin
            asm_q    <= asm_d;
            idx_q    <= idx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            drop_q   <= drop_d;
            abort_q  <= abort_d;
        end
    end

    // Frame storage; contents are only observed through valid pointers.
    always_ff @(posedge traceClkin) begin
        if (!rst && push_s) begin
            buf_q[wr_ptr_q[AW-1:0]] <= {bus.PacketWd, asm_q};
        end
    end

    assign bus.FrameValid = (fill_s != {PW{1'b0}});
    assign bus.FrameData  = buf_q[rd_ptr_q[AW-1:0]];
    assign bus.fill       = fill_s;
    assign bus.dropCount  = drop_q;
    assign bus.abortCount = abort_q;
endmodule

// File: tb/tb_trace_frame_assembler.sv
// Directed self-checking bench for trace_frame_assembler with DEPTH=4.
module tb_trace_frame_assembler;
    logic traceClkin = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    trace_frame_assembler_if #(.DEPTH(4), .CNTW(16)) bus ();

    trace_frame_assembler #(.DEPTH(4), .CNTW(16)) dut (
        .traceClkin (traceClkin),
        .rst        (rst),
        .bus        (bus.slave)
    );

    always #5 traceClkin = ~traceClkin;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge traceClkin);
        #1;
    endtask

    function automatic logic [127:0] exp_frame(input logic [15:0] base);
        logic [127:0] f;
        f = 128'd0;
        for (int k = 0; k < 8; k++) f[16*k +: 16] = base + 16'(k);
        return f;
    endfunction

    task automatic send_words(input logic [15:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            bus.WdAvail  = 1'b1;
            bus.PacketWd = base + 16'(k);
            tick();
        end
        bus.WdAvail = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] base, input bit rdy_last);
        for (int k = 0; k < 8; k++) begin
            bus.WdAvail  = 1'b1;
            bus.PacketWd = base + 16'(k);
            if (k == 7 && rdy_last) bus.FrameReady = 1'b1;
            tick();
        end
        bus.WdAvail = 1'b0;
        if (rdy_last) bus.FrameReady = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [15:0] base);
        check_eq(tag, {127'd0, bus.FrameValid}, 128'd1);
        check_eq(tag, bus.FrameData, exp_frame(base));
        bus.FrameReady = 1'b1;
        tick();
        bus.FrameReady = 1'b0;
    endtask

    initial begin
        int popped;
        rst             = 1'b1;
        bus.WdAvail     = 1'b0;
        bus.PacketWd    = 16'h0000;
        bus.PacketReset = 1'b0;
        bus.FrameReady  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_valid", {127'd0, bus.FrameValid}, 128'd0);
        check_eq("rst_fill",  128'(bus.fill), 128'd0);
        check_eq("rst_drop",  128'(bus.dropCount), 128'd0);
        check_eq("rst_abort", 128'(bus.abortCount), 128'd0);

        // Basic frame, consumer always ready.
        bus.FrameReady = 1'b1;
        send_frame(16'h0001, 1'b0);
        check_eq("basic_valid", {127'd0, bus.FrameValid}, 128'd1);
        check_eq("basic_data", bus.FrameData, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        tick();
        bus.FrameReady = 1'b0;
        check_eq("basic_fill", 128'(bus.fill), 128'd0);
        check_eq("basic_valid_off", {127'd0, bus.FrameValid}, 128'd0);

        // Resync abort.
        send_words(16'h5000, 3);
        bus.PacketReset = 1'b1;
        tick();
        bus.PacketReset = 1'b0;
        check_eq("abort_cnt", 128'(bus.abortCount), 128'd1);
        bus.PacketReset = 1'b1;
        tick();
        bus.PacketReset = 1'b0;
        check_eq("abort_idle", 128'(bus.abortCount), 128'd1);
        send_frame(16'hA000, 1'b0);
        check_eq("abort_fill", 128'(bus.fill), 128'd1);
        pop_expect("abort_frame", 16'hA000);
        check_eq("abort_empty", 128'(bus.fill), 128'd0);

        // Overflow: six frames into four slots.
        for (int i = 0; i < 6; i++) send_frame(16'h1100 + 16'(i * 16'h0100), 1'b0);
        check_eq("ovf_fill", 128'(bus.fill), 128'd4);
        check_eq("ovf_drop", 128'(bus.dropCount), 128'd2);
        for (int i = 0; i < 4; i++) pop_expect("ovf_order", 16'h1100 + 16'(i * 16'h0100));
        check_eq("ovf_empty", 128'(bus.fill), 128'd0);

        // Full buffer with push and pop in the same cycle.
        for (int i = 0; i < 4; i++) send_frame(16'h2100 + 16'(i * 16'h0100), 1'b0);
        send_frame(16'h2500, 1'b1);
        check_eq("full_fill", 128'(bus.fill), 128'd4);
        check_eq("full_drop", 128'(bus.dropCount), 128'd2);
        for (int i = 0; i < 4; i++) pop_expect("full_order", 16'h2200 + 16'(i * 16'h0100));

        // PacketReset colliding with the 8th word.
        send_words(16'h6000, 7);
        bus.WdAvail     = 1'b1;
        bus.PacketWd    = 16'h6007;
        bus.PacketReset = 1'b1;
        tick();
        bus.WdAvail     = 1'b0;
        bus.PacketReset = 1'b0;
        check_eq("coll_abort", 128'(bus.abortCount), 128'd2);
        check_eq("coll_fill", 128'(bus.fill), 128'd0);
        send_frame(16'h7ff9, 1'b0);
        pop_expect("coll_next", 16'h7ff9);

        // rst with three frames buffered and a partial frame pending.
        for (int i = 0; i < 3; i++) send_frame(16'h4100 + 16'(i * 16'h0100), 1'b0);
        send_words(16'h4f00, 2);
        check_eq("pre_rst_fill", 128'(bus.fill), 128'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mid_rst_valid", {127'd0, bus.FrameValid}, 128'd0);
        check_eq("mid_rst_fill", 128'(bus.fill), 128'd0);
        check_eq("mid_rst_drop", 128'(bus.dropCount), 128'd0);
        check_eq("mid_rst_abort", 128'(bus.abortCount), 128'd0);
        send_frame(16'h4500, 1'b0);
        pop_expect("post_rst", 16'h4500);

        // Wrap-around stream with random ready of at least 50% duty.
        popped = 0;
        for (int c = 0; c < 200; c++) begin
            if (c < 160) begin
                bus.WdAvail  = 1'b1;
                bus.PacketWd = 16'h3000 + 16'((c / 8) * 16 + (c % 8));
                bus.FrameReady = ((c % 2) == 1) || ($urandom_range(0, 1) == 1);
            end else begin
                bus.WdAvail    = 1'b0;
                bus.FrameReady = 1'b1;
            end
            if (bus.FrameValid && bus.FrameReady) begin
                if (popped < 20)
                    check_eq("wrap_data", bus.FrameData, exp_frame(16'h3000 + 16'(popped * 16)));
                popped++;
            end
            tick();
        end
        bus.WdAvail    = 1'b0;
        bus.FrameReady = 1'b0;
        check_eq("wrap_count", 128'(popped), 128'd20);
        check_eq("wrap_drop", 128'(bus.dropCount), 128'd0);
        check_eq("wrap_fill", 128'(bus.fill), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/trace_frame_assembler.md
# trace_frame_assembler

Sits directly downstream of the trace pin interface in the `traceClkin` domain. Gathers the 16-bit `PacketWd` words it emits into 128-bit, 8-halfword TPIU frames and discards partial frames on `PacketReset`. Queues completed frames in a small buffer behind a valid/ready handshake for the frame demultiplexer, and counts frames lost to overflow or aborted by resync.

## Interface
- `DEPTH`, default 4: frame buffer entries; power of two, minimum 2.
- `CNTW`, default 16: width of the drop and abort counters.

- `traceClkin`  in  1  clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `WdAvail`  in  1  one-cycle strobe: `PacketWd` holds a new word.
- `PacketWd`  in  16  trace word, in arrival order.
- `PacketReset`  in  1  resync seen; discard any partial frame.
- `FrameValid`  out  1  head of buffer holds a complete frame.
- `FrameData`  out  128  head frame; word k at [16k+15:16k], k=0 first received.
- `FrameReady`  in  1  consumer accepts head frame this cycle.
- `fill`  out  $clog2(DEPTH)+1  frames currently buffered.
- `dropCount`  out  CNTW  complete frames lost because the buffer was full.
- `abortCount`  out  CNTW  partial frames discarded by `PacketReset`.

## Operation
- State: assembly register `asm[111:0]` (words 0..6), word index `idx[2:0]`, circular buffer with read/write pointers of $clog2(DEPTH)+1 bits, counters.
- Reset values:
  - `idx`=0, pointers=0, `fill`=0.
  - `FrameValid`=0, `dropCount`=0, `abortCount`=0.
  - `FrameData` is don't-care while `FrameValid`=0.
- `PacketReset`=1:
  - `idx`→0.
  - If `idx`≠0, `abortCount` increments (saturating at all-ones).
  - Overrides `WdAvail` in the same cycle; that word is discarded.
  - Buffered complete frames are kept.
- `WdAvail`=1, `PacketReset`=0, `idx`<7: `asm[16*idx +: 16]`←`PacketWd`, `idx`←`idx`+1.
- `WdAvail`=1, `PacketReset`=0, `idx`=7:
  - Frame is `{PacketWd, asm}`; `idx`→0.
  - Push condition: `fill`<`DEPTH`, or a pop occurs in the same cycle.
  - If the push condition holds, the frame is written at the write pointer.
  - Otherwise the frame is dropped and `dropCount` increments (saturating).
- Pop: occurs when `FrameValid`∧`FrameReady`; read pointer advances.
  - `FrameReady` while `FrameValid`=0 has no effect.
- `fill` = write pointer − read pointer (modulo 2·DEPTH).
  - Full: `fill`=DEPTH. Empty: `fill`=0.
  - Simultaneous push and pop leaves `fill` unchanged, including when full.
- `FrameValid` = (`fill`≠0). `FrameData` = buffer[read pointer].
- Pointer wrap at DEPTH is handled by the extra MSB; no entry is ever overwritten.
- `WdAvail`=0 and `PacketReset`=0: assembly state holds.
- A `PacketWd` value of 16'h7fff is stored like any other word; filtering happens upstream.

## Timing
- Latency: 8th word strobed at edge N, buffer empty → `FrameValid`=1 after edge N, with `FrameData` valid the same cycle.
- Back-to-back `WdAvail` on every cycle is supported. The sustained rate is one frame per 8 cycles; the consumer needs `FrameReady` ≥1/8 duty to avoid drops.
- The handshake is AXI-stream style:
  - Once `FrameValid`=1, `FrameData` is stable until popped.
  - `FrameValid` never deasserts without a pop, except on `rst`.
- `rst` mid-frame or with a non-empty buffer: all state clears at the next edge; no partial output.
- Counters update one edge after the causing event.
- Outputs are registered or driven from the buffer RAM read; there is no combinational path from `WdAvail`/`PacketWd` to `FrameValid`/`FrameData`.
- A combinational path from `FrameReady` to the push-accept decision is permitted.

## Test plan
- Basic frame: 8 strobes of words 0x0001..0x0008, `FrameReady`=1 → one cycle later `FrameValid`=1, `FrameData`=0x0008_0007_0006_0005_0004_0003_0002_0001; popped the same cycle; `fill` back to 0.
- Resync abort: 3 words, then `PacketReset`, then 8 words 0xA000..0xA007 → `abortCount`=1; exactly one frame holding 0xA000..0xA007; `PacketReset` with `idx`=0 leaves `abortCount` unchanged.
- Overflow: `FrameReady`=0, 6 frames, DEPTH=4 → `fill`=4, `dropCount`=2; the 4 buffered frames pop in arrival order as frames 1–4.
- Full with simultaneous push and pop: buffer full, `FrameReady`=1 on the cycle the 8th word arrives → `dropCount` unchanged, `fill` stays 4, frame order preserved.
- Collision and reset: `PacketReset` and `WdAvail` together at `idx`=7 → no frame, `abortCount`+1. Separately, `rst` with `fill`=3 → `FrameValid`=0, all counters 0 next cycle.
- Wrap-around: 20 frames streamed with random `FrameReady` (≥50% duty) → every frame delivered intact and in order, `dropCount`=0.
